// File: rtl/regfile_write_queue_pkg.sv
// regfile_write_queue_pkg: register file geometry and write-queue sizing shared with the regfile
package regfile_write_queue_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DEPTH = 4;
    localparam int REGFILE_DEPTH = 32;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_write_queue_fifo.sv
// regfile_write_queue_fifo: in-order entry storage, exposing every entry oldest-first with its valid bit
module regfile_write_queue_fifo #(
    parameter int WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [ADDR_WIDTH-1:0]   push_reg,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic [ADDR_WIDTH-1:0]   entry_reg [DEPTH],
    output logic [WIDTH-1:0]        entry_data [DEPTH],
    output logic [DEPTH-1:0]        entry_valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [ADDR_WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr] <= push_reg;
            mem_data[wr_ptr] <= push_data;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    for (genvar i = 0; i < DEPTH; i++) begin : g_age
        assign entry_reg[i] = mem_reg[rd_ptr + PW'(i)];
        assign entry_data[i] = mem_data[rd_ptr + PW'(i)];
        assign entry_valid[i] = count > CW'(i);
    end
endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: load/ALU write-back queue draining into the regfile write port with read bypass
module regfile_write_queue
    import regfile_write_queue_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    MemValid,
    input  logic [ADDR_WIDTH-1:0]   MemRegister,
    input  logic [WIDTH-1:0]        MemData,
    output logic                    MemReady,
    input  logic                    AluValid,
    input  logic [ADDR_WIDTH-1:0]   AluRegister,
    input  logic [WIDTH-1:0]        AluData,
    output logic                    AluReady,
    input  logic                    DrainEnable,
    output logic [ADDR_WIDTH-1:0]   WriteRegister,
    output logic [WIDTH-1:0]        WriteData,
    output logic                    RegWrite,
    input  logic [ADDR_WIDTH-1:0]   ReadRegister1,
    input  logic [ADDR_WIDTH-1:0]   ReadRegister2,
    input  logic [WIDTH-1:0]        RegFileData1,
    input  logic [WIDTH-1:0]        RegFileData2,
    output logic [WIDTH-1:0]        ReadData1,
    output logic [WIDTH-1:0]        ReadData2,
    output logic [$clog2(DEPTH):0]  Count,
    output logic                    Full,
    output logic                    Empty
);
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);
    logic push;
    logic [ADDR_WIDTH-1:0] push_reg;
    logic [WIDTH-1:0] push_data;
    logic [ADDR_WIDTH-1:0] entry_reg [DEPTH];
    logic [WIDTH-1:0] entry_data [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    assign MemReady = !Reset && !Full;
    assign AluReady = !Reset && !Full && !MemValid;
    assign push_reg = MemValid ? MemRegister : AluRegister;
    assign push_data = MemValid ? MemData : AluData;
    assign push = ((MemValid && MemReady) || (AluValid && AluReady)) && push_reg != ZERO;
    assign RegWrite = !Empty && DrainEnable && !Reset;
    assign WriteRegister = Empty ? '0 : entry_reg[0];
    assign WriteData = Empty ? '0 : entry_data[0];
    regfile_write_queue_fifo #(
        .WIDTH(WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk(Clk),
        .rst(Reset),
        .push(push),
        .push_reg(push_reg),
        .push_data(push_data),
        .pop(RegWrite),
        .count(Count),
        .full(Full),
        .empty(Empty),
        .entry_reg(entry_reg),
        .entry_data(entry_data),
        .entry_valid(entry_valid)
    );
    always_comb begin
        ReadData1 = RegFileData1;
        ReadData2 = RegFileData2;
        for (int i = 0; i < DEPTH; i++) begin
            ReadData1 = (entry_valid[i] && entry_reg[i] == ReadRegister1 && ReadRegister1 != ZERO) ? entry_data[i] : ReadData1;
            ReadData2 = (entry_valid[i] && entry_reg[i] == ReadRegister2 && ReadRegister2 != ZERO) ? entry_data[i] : ReadData2;
        end
    end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed vector table plus hand sequences against a behavioural regfile
module tb_regfile_write_queue;
    import regfile_write_queue_pkg::*;
    logic Clk = 0;
    logic Reset = 1;
    logic MemValid = 0, AluValid = 0, DrainEnable = 0;
    logic [4:0] MemRegister = 0, AluRegister = 0, ReadRegister1 = 0, ReadRegister2 = 0;
    logic [31:0] MemData = 0, AluData = 0;
    logic MemReady, AluReady, RegWrite, Full, Empty;
    logic [4:0] WriteRegister;
    logic [31:0] WriteData, RegFileData1, RegFileData2, ReadData1, ReadData2;
    logic [2:0] Count;
    logic [31:0] rf [REGFILE_DEPTH] = '{default: 32'd0};
    int nwrites = 0;
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (RegWrite) begin
            rf[WriteRegister] <= WriteData;
            nwrites <= nwrites + 1;
        end
    end
    assign RegFileData1 = rf[ReadRegister1];
    assign RegFileData2 = rf[ReadRegister2];

    regfile_write_queue dut (
        .Clk(Clk), .Reset(Reset),
        .MemValid(MemValid), .MemRegister(MemRegister), .MemData(MemData), .MemReady(MemReady),
        .AluValid(AluValid), .AluRegister(AluRegister), .AluData(AluData), .AluReady(AluReady),
        .DrainEnable(DrainEnable), .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .RegFileData1(RegFileData1), .RegFileData2(RegFileData2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Count(Count), .Full(Full), .Empty(Empty)
    );

    typedef struct {
        logic mv; logic [4:0] mreg; logic [31:0] mdat;
        logic av; logic [4:0] areg; logic [31:0] adat;
        logic de; logic [4:0] r1; logic [4:0] r2;
        logic emr; logic ear; logic erw; logic [4:0] ewr; logic [31:0] ewd; logic [2:0] ecnt;
        logic [31:0] erd1; logic [31:0] erd2;
    } vec_t;
    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] mreg, input logic [31:0] mdat,
                         input logic av, input logic [4:0] areg, input logic [31:0] adat, input logic de);
        MemValid = mv; MemRegister = mreg; MemData = mdat;
        AluValid = av; AluRegister = areg; AluData = adat;
        DrainEnable = de;
    endtask

    initial begin
        int snap;
        int exp_wr [5] = '{5, 6, 7, 8, 9};
        int exp_cnt [5] = '{4, 3, 3, 2, 1};
        int exp_mr [5] = '{0, 1, 1, 1, 1};
        vecs[0]  = '{0, 0, 0,  0, 0, 0,   1, 0, 0,   1, 1, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 2, 42, 0, 0, 0,   1, 2, 4,   1, 0, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0,  0, 0, 0,   1, 2, 2,   1, 1, 1, 2, 42, 1, 42, 42};
        vecs[3]  = '{0, 0, 0,  0, 0, 0,   1, 2, 3,   1, 1, 0, 0, 0, 0, 42, 0};
        vecs[4]  = '{1, 4, 7,  1, 3, 15,  1, 4, 3,   1, 0, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 0,  1, 3, 15,  1, 4, 3,   1, 1, 1, 4, 7, 1, 7, 0};
        vecs[6]  = '{0, 0, 0,  0, 0, 0,   1, 3, 4,   1, 1, 1, 3, 15, 1, 15, 7};
        vecs[7]  = '{0, 0, 0,  0, 0, 0,   1, 4, 3,   1, 1, 0, 0, 0, 0, 7, 15};
        vecs[8]  = '{1, 0, 42, 0, 0, 0,   1, 0, 2,   1, 0, 0, 0, 0, 0, 0, 42};
        vecs[9]  = '{0, 0, 0,  0, 0, 0,   1, 0, 12,  1, 1, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{1, 12, 42, 0, 0, 0,  0, 12, 2,  1, 0, 0, 0, 0, 0, 0, 42};
        vecs[11] = '{0, 0, 0,  1, 12, 40, 0, 12, 3,  1, 1, 0, 12, 42, 1, 42, 15};
        vecs[12] = '{0, 0, 0,  0, 0, 0,   0, 12, 4,  1, 1, 0, 12, 42, 2, 40, 7};
        vecs[13] = '{0, 0, 0,  0, 0, 0,   1, 12, 2,  1, 1, 1, 12, 42, 2, 40, 42};
        vecs[14] = '{0, 0, 0,  0, 0, 0,   1, 2, 12,  1, 1, 1, 12, 40, 1, 42, 40};
        vecs[15] = '{0, 0, 0,  0, 0, 0,   1, 12, 0,  1, 1, 0, 0, 0, 0, 40, 0};

        @(negedge Clk);
        drive(1, 2, 99, 1, 3, 98, 1);
        #1;
        chk("reset_regwrite", RegWrite, 0);
        chk("reset_memready", MemReady, 0);
        chk("reset_aluready", AluReady, 0);
        chk("reset_count", Count, 0);
        chk("reset_empty", Empty, 1);
        chk("reset_full", Full, 0);
        Reset = 0;
        drive(0, 0, 0, 0, 0, 0, 1);

        for (int v = 0; v < 16; v++) begin
            @(negedge Clk);
            drive(vecs[v].mv, vecs[v].mreg, vecs[v].mdat, vecs[v].av, vecs[v].areg, vecs[v].adat, vecs[v].de);
            ReadRegister1 = vecs[v].r1;
            ReadRegister2 = vecs[v].r2;
            #1;
            chk($sformatf("v%0d_memready", v), MemReady, vecs[v].emr);
            chk($sformatf("v%0d_aluready", v), AluReady, vecs[v].ear);
            chk($sformatf("v%0d_regwrite", v), RegWrite, vecs[v].erw);
            chk($sformatf("v%0d_writereg", v), WriteRegister, vecs[v].ewr);
            chk($sformatf("v%0d_writedata", v), WriteData, vecs[v].ewd);
            chk($sformatf("v%0d_count", v), Count, vecs[v].ecnt);
            chk($sformatf("v%0d_empty", v), Empty, vecs[v].ecnt == 0);
            chk($sformatf("v%0d_full", v), Full, vecs[v].ecnt == 4);
            chk($sformatf("v%0d_readdata1", v), ReadData1, vecs[v].erd1);
            chk($sformatf("v%0d_readdata2", v), ReadData2, vecs[v].erd2);
        end
        chk("rf_reg4", rf[4], 7);
        chk("rf_reg3", rf[3], 15);
        chk("rf_reg12", rf[12], 40);
        chk("rf_reg0", rf[0], 0);

        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            if (k % 2 == 0) drive(1, 5'(5 + k), 32'(50 + 10 * k), 0, 0, 0, 0);
            else drive(0, 0, 0, 1, 5'(5 + k), 32'(50 + 10 * k), 0);
            #1;
            chk($sformatf("fill%0d_ready", k), (k % 2 == 0) ? MemReady : AluReady, 1);
            chk($sformatf("fill%0d_count", k), Count, k);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            drive(1, 9, 90, 1, 14, 140, 0);
            #1;
            chk($sformatf("full%0d_count", k), Count, 4);
            chk($sformatf("full%0d_full", k), Full, 1);
            chk($sformatf("full%0d_memready", k), MemReady, 0);
            chk($sformatf("full%0d_aluready", k), AluReady, 0);
            chk($sformatf("full%0d_regwrite", k), RegWrite, 0);
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge Clk);
            drive(j < 2, 9, 90, 0, 0, 0, 1);
            #1;
            chk($sformatf("drain%0d_regwrite", j), RegWrite, 1);
            chk($sformatf("drain%0d_writereg", j), WriteRegister, exp_wr[j]);
            chk($sformatf("drain%0d_writedata", j), WriteData, exp_wr[j] * 10);
            chk($sformatf("drain%0d_count", j), Count, exp_cnt[j]);
            chk($sformatf("drain%0d_memready", j), MemReady, exp_mr[j]);
        end
        @(negedge Clk);
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("drained_regwrite", RegWrite, 0);
        chk("drained_empty", Empty, 1);
        chk("rf_reg5", rf[5], 50);
        chk("rf_reg8", rf[8], 80);
        chk("rf_reg9", rf[9], 90);

        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            drive(1, 5'(10 + k), 32'(100 + k), 0, 0, 0, 0);
        end
        @(negedge Clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("prereset_count", Count, 3);
        snap = nwrites;
        @(negedge Clk);
        Reset = 1;
        drive(1, 15, 150, 0, 0, 0, 1);
        #1;
        chk("midreset_regwrite", RegWrite, 0);
        chk("midreset_memready", MemReady, 0);
        chk("midreset_aluready", AluReady, 0);
        @(negedge Clk);
        Reset = 0;
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("postreset_count", Count, 0);
        chk("postreset_empty", Empty, 1);
        chk("postreset_regwrite", RegWrite, 0);
        repeat (3) @(negedge Clk);
        #1;
        chk("postreset_nwrites", nwrites, snap);
        chk("postreset_rf10", rf[10], 0);
        chk("postreset_rf11", rf[11], 0);
        chk("postreset_rf12", rf[12], 40);
        chk("postreset_rf15", rf[15], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
